// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the memory stage: funct3 load/store codes,
// EX/MEM control bit positions and the LSU state encoding.
package rv32i_pkg;

    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_BRANCH = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Byte enables for an access of the size given by funct3[1:0].
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3[1:0])
            F3_SB[1:0]: be = 4'b0001 << addr_lo;
            F3_SH[1:0]: be = 4'b0011 << {addr_lo[1], 1'b0};
            F3_SW[1:0]: be = 4'b1111;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load data alignment: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it to 32 bits.
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_out = rdata;
        case (funct3)
            F3_LB:   data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_out = {24'h0, byte_sel};
            F3_LH:   data_out = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_out = {16'h0, half_sel};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per EX/MEM access,
// stalling upstream until the access finishes or times out.
module rv32i_lsu
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  CTRL_MEM_IN,
    input  logic [31:0] ADDR_IN,
    input  logic [31:0] WDATA_IN,
    input  logic [31:0] INST_IN,
    output logic        D_REQ,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic        D_ACK,
    input  logic [31:0] D_RDATA,
    output logic [31:0] RDATA_OUT,
    output logic        STALL,
    output logic        MISALIGN,
    output logic        BUS_ERR
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;

    logic        mem_read, mem_write, access, misalign_raw;
    logic [2:0]  funct3;
    logic [31:0] store_data, load_data;
    logic        unused_ok;

    assign mem_read  = CTRL_MEM_IN[CTRL_MEM_READ];
    assign mem_write = CTRL_MEM_IN[CTRL_MEM_WRITE];
    assign access    = mem_read | mem_write;
    assign funct3    = INST_IN[14:12];
    assign unused_ok = &{1'b0, CTRL_MEM_IN[CTRL_MEM_BRANCH], INST_IN[31:15], INST_IN[11:0]};

    always_comb begin
        misalign_raw = 1'b0;
        store_data   = WDATA_IN;
        case (funct3[1:0])
            F3_SB[1:0]: begin
                misalign_raw = 1'b0;
                store_data   = {4{WDATA_IN[7:0]}};
            end
            F3_SH[1:0]: begin
                misalign_raw = ADDR_IN[0];
                store_data   = {2{WDATA_IN[15:0]}};
            end
            default: begin
                misalign_raw = |ADDR_IN[1:0];
                store_data   = WDATA_IN;
            end
        endcase
    end

    assign MISALIGN = access & misalign_raw;

    // Held low during reset so an abandoned access never freezes the pipeline.
    assign STALL = !RST & (((state_q == ST_IDLE) & access & !MISALIGN) | (state_q == ST_REQ));

    rv32i_load_align u_load_align (
        .rdata    (D_RDATA),
        .addr_lo  (lo_q),
        .funct3   (f3_q),
        .data_out (load_data)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && !MISALIGN) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {ADDR_IN[31:2], 2'b00};
                    be_d    = byte_enables(funct3, ADDR_IN[1:0]);
                    wdata_d = store_data;
                    f3_d    = funct3;
                    lo_d    = ADDR_IN[1:0];
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (D_ACK) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign D_REQ     = req_q;
    assign D_WE      = we_q;
    assign D_ADDR    = addr_q;
    assign D_BE      = be_q;
    assign D_WDATA   = wdata_q;
    assign RDATA_OUT = rdata_q;
    assign BUS_ERR   = bus_err_q;

endmodule
